// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the pipeline hazard controller
package core_pkg;

    // Operand source selects for the Execute-stage forwarding muxes
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } forward_sel_e;

    // Data-memory access sequencer states
    typedef enum logic [1:0] {
        MEM_IDLE  = 2'b00,
        MEM_WAIT  = 2'b01,
        MEM_ABORT = 2'b10
    } mem_fsm_e;

    // x0 is hardwired to zero and never a forwarding or hazard source
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - combinational forwarding comparator for one Execute operand
module fwd_unit
    import core_pkg::*;
(
    input  logic [4:0]   rs,
    input  logic [4:0]   rd_m,
    input  logic         reg_write_m,
    input  logic [4:0]   rd_w,
    input  logic         reg_write_w,
    output forward_sel_e sel
);

    // The younger result in Memory wins over the older one in Writeback
    always_comb begin
        sel = FWD_RF;
        if (reg_write_m && (rd_m != REG_ZERO) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (reg_write_w && (rd_w != REG_ZERO) && (rd_w == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forward sequencer for the 5-stage RV32I pipeline
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemBusy,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCount
);

    // MEM_TIMEOUT is at most 255, so an 8-bit wait counter always suffices
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    mem_fsm_e     state;
    mem_fsm_e     state_next;
    logic [7:0]   wait_cnt;
    logic [7:0]   wait_cnt_next;
    forward_sel_e fwd_a;
    forward_sel_e fwd_b;
    logic         lw_stall;
    logic         mem_stall;

    fwd_unit u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .sel         (fwd_a)
    );

    fwd_unit u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .sel         (fwd_b)
    );

    // A load in Execute feeding an operand in Decode needs one bubble;
    // a pending memory access holds everything, except in the abort cycle
    always_comb begin
        lw_stall  = ResultSrcE0 && (RdE != REG_ZERO) && ((RdE == Rs1D) || (RdE == Rs2D));
        mem_stall = MemReqM && !MemReadyM && (state != MEM_ABORT);
    end

    // Memory sequencer next state: wait for ready, give up after MEM_TIMEOUT stall cycles
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            MEM_IDLE: begin
                if (mem_stall) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (MemReadyM) begin
                    state_next    = MEM_IDLE;
                    wait_cnt_next = 8'd0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = MEM_ABORT;
                end else begin
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end
            default: begin
                state_next    = MEM_IDLE;
                wait_cnt_next = 8'd0;
            end
        endcase
    end

    // Pipeline controls: a memory stall freezes the whole pipe and hides
    // lw_stall/PCSrcE, which re-present once Execute is released
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (reset) begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                if (lw_stall) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
                if (PCSrcE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end
                // The timed-out load must not reach the register file
                if (state == MEM_ABORT) begin
                    FlushW = 1'b1;
                end
            end
        end
    end

    assign MemBusy = (state == MEM_WAIT);

    // State, sticky error flag and saturating stall counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= MEM_IDLE;
            wait_cnt   <= 8'd0;
            MemErr     <= 1'b0;
            StallCount <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (state == MEM_ABORT) begin
                MemErr <= 1'b1;
            end
            if (StallF && (StallCount != {CNT_W{1'b1}})) begin
                StallCount <= StallCount + 1'b1;
            end
        end
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RV32I core.
- Drives the stall and flush controls for every pipeline register (if_id, id_ex, ex_mem, mem_wb) and the forwarding mux selects.
- Sequences multi-cycle data-memory accesses through a ready/timeout FSM.
- Sits beside the datapath. It takes register indices and control bits from the D/E/M/W stages and returns enables and clears.

Parameters:
- MEM_TIMEOUT, 16, maximum stall cycles for one data-memory access before abort. Legal range 2..255.
- CNT_W, 32, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous reset, active-low.
- Rs1D, Rs2D  in  5 each  source registers in Decode.
- Rs1E, Rs2E, RdE  in  5 each  source and destination registers in Execute.
- ResultSrcE0  in  1  bit 0 of ResultSrcE; 1 means the E instruction is a load.
- PCSrcE  in  1  taken branch/jump resolved in Execute.
- RdM  in  5  destination register in Memory.
- RegWriteM  in  1  M stage writes the register file.
- MemReqM  in  1  M instruction accesses data memory (load or store).
- MemReadyM  in  1  data memory completes the access this cycle.
- RdW  in  5  destination register in Writeback.
- RegWriteW  in  1  W stage writes the register file.
- StallF, StallD, StallE, StallM  out  1 each  hold the PC and the if_id / id_ex / ex_mem registers.
- FlushD, FlushE, FlushW  out  1 each  clear if_id / id_ex / mem_wb to a bubble on the next edge.
- ForwardAE, ForwardBE  out  2 each  00 = register file, 10 = ALUResultM, 01 = ResultW.
- MemBusy  out  1  FSM is in WAIT.
- MemErr  out  1  sticky flag: a memory access timed out.
- StallCount  out  CNT_W  saturating count of cycles with StallF=1.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State is IDLE; WaitCnt, MemErr and StallCount are 0.
  - While reset is low, every stall, flush and Forward output is forced to 0.
- Forwarding (combinational):
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Otherwise ForwardAE=01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Otherwise ForwardAE=00.
  - The M stage wins over the W stage. ForwardBE is identical using Rs2E.
- Load-use hazard: lwStall = ResultSrcE0 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- Memory stall: memStall = MemReqM && !MemReadyM && state!=ABORT.
- FSM states: IDLE, WAIT, ABORT.
  - IDLE: if memStall, go to WAIT and set WaitCnt=1; otherwise stay in IDLE.
  - WAIT:
    - MemReadyM=1: go to IDLE, WaitCnt=0.
    - Else if WaitCnt==MEM_TIMEOUT-1: go to ABORT.
    - Else: WaitCnt+1.
  - ABORT (lasts exactly one cycle):
    - Stalls are released.
    - FlushW=1, which discards the failed load in mem_wb.
    - MemErr is set on the edge; next state IDLE, WaitCnt=0.
- Output priority:
  - memStall: StallF=StallD=StallE=StallM=1 and FlushW=1. FlushD and FlushE are forced to 0. lwStall and PCSrcE are ignored; E is frozen, so they re-present after release.
  - Else lwStall: StallF=StallD=1, FlushE=1.
  - PCSrcE: FlushD=1, FlushE=1. This OR's with lwStall (a branch in E outranks the load-use bubble; both flush E).
- Latency:
  - Stall and flush outputs are combinational from current inputs and state, so they take effect on the next edge.
  - A zero-wait access (MemReadyM=1 on the request cycle) causes no stall and no FSM transition.
- StallCount increments each cycle StallF=1 and saturates at all-ones.
- MemErr clears only on reset.
- A reset during WAIT aborts the access silently: no MemErr, state IDLE.

Decomposition:
- Shared package core_pkg holds:
  - The ForwardSel enum (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
  - The MemFsm state enum.
  - The REG_ZERO=5'd0 constant.
- One natural sub-module, fwd_unit: the purely combinational forwarding comparator, instantiated twice (A and B operands).

Test Plan:
- Forwarding:
  - RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5 -> ForwardAE=10.
  - Then RegWriteM=0 -> ForwardAE=01.
  - RdM=RdW=0 with matching Rs1E=0 -> ForwardAE=00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; StallCount increments by 1.
- Branch during load-use: lwStall and PCSrcE=1 together -> StallF=StallD=1, FlushD=FlushE=1.
- Slow memory: MemReqM=1, MemReadyM low for 3 cycles then high -> StallF..StallM=1 and FlushW=1 for exactly 3 cycles; MemBusy high for 2 cycles; MemErr=0.
- Timeout with MEM_TIMEOUT=4: MemReqM=1, MemReadyM=0 held.
  - 4 stall cycles occur.
  - Then one ABORT cycle with stalls=0 and FlushW=1.
  - MemErr=1 from the next cycle and persists until reset.
- Reset mid-WAIT: drive reset=0 during the 2nd wait cycle -> all outputs 0 and state IDLE next cycle; MemErr=0; StallCount=0.
